// File: rtl/dma_pkg.sv
// dma_pkg
// Shared types for the DMA streamer pair and its scheduler.
//   dma_err_src_e   : error source reported by a streamer or by the scheduler watchdog
//   s_dma_desc_t    : transfer descriptor (source, destination, byte count)
//   s_dma_error_t   : error record, valid + source + faulting address
//   dma_sched_st_t  : scheduler state encoding
package dma_pkg;

  typedef enum logic [2:0] {
    DMA_NO_ERR        = 3'd0,
    DMA_UNALIGNED_ERR = 3'd1,
    DMA_BUS_ERR       = 3'd2,
    DMA_DECODE_ERR    = 3'd3,
    DMA_TIMEOUT_ERR   = 3'd4
  } dma_err_src_e;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic         valid;
    dma_err_src_e src;
    logic [31:0]  addr;
  } s_dma_error_t;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_GO,
    SCHED_RUN,
    SCHED_RESP,
    SCHED_HALT
  } dma_sched_st_t;

  // Width of the RUN-state watchdog counter.
  localparam int WD_W = 16;

endpackage

// File: rtl/dma_stream_sched_if.sv
// dma_stream_sched_if
// Control bundle between the stream scheduler and the read/write streamer pair.
//   dma_go_o / dma_desc_o            : descriptor load strobe and descriptor
//   rd/wr_stream_valid_o             : per-streamer enable
//   rd/wr_stream_done_i              : per-streamer completion pulse
//   rd/wr_stream_err_i               : per-streamer (sticky) error status
// master = scheduler side, slave = streamer side.
interface dma_stream_sched_if;
  import dma_pkg::*;

  logic         dma_go_o;
  s_dma_desc_t  dma_desc_o;
  logic         rd_stream_valid_o;
  logic         wr_stream_valid_o;
  logic         rd_stream_done_i;
  logic         wr_stream_done_i;
  s_dma_error_t rd_stream_err_i;
  s_dma_error_t wr_stream_err_i;

  modport master (
    output dma_go_o, dma_desc_o, rd_stream_valid_o, wr_stream_valid_o,
    input  rd_stream_done_i, wr_stream_done_i, rd_stream_err_i, wr_stream_err_i
  );

  modport slave (
    input  dma_go_o, dma_desc_o, rd_stream_valid_o, wr_stream_valid_o,
    output rd_stream_done_i, wr_stream_done_i, rd_stream_err_i, wr_stream_err_i
  );

endinterface

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter
// Combinational round-robin arbiter: the first requester found scanning upward
// from ptr_i (wrapping) wins.
//   req_i       : request vector
//   ptr_i       : highest-priority channel this cycle
//   grant_o     : one-hot grant (all zero when nothing requests)
//   grant_idx_o : index of the granted channel
module dma_rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  grant_idx_o
);

  logic             found;
  logic [IDX_W-1:0] sel;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    sel         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel = IDX_W'((int'(ptr_i) + i) % NUM_CH);
      if (!found && req_i[sel]) begin
        found        = 1'b1;
        grant_o[sel] = 1'b1;
        grant_idx_o  = sel;
      end
    end
  end

endmodule

// File: rtl/dma_stream_sched.sv
// dma_stream_sched
// Schedules descriptors from NUM_CH requesters onto one read/write streamer pair.
// A round-robin winner is accepted in IDLE, loaded with a one-cycle go pulse,
// run until both streamers report done, then acknowledged per channel. Streamer
// errors or the RUN watchdog stop the pair in HALT until software clears it.
//   clk, rstn          : clock, asynchronous active-low reset
//   ch_req_valid_i     : per-channel descriptor pending
//   ch_desc_i          : per-channel descriptor
//   ch_req_ready_o     : one-hot accept (combinational, IDLE only)
//   ch_done_o          : one-cycle completion pulse
//   ch_err_o/_id_o     : error record (valid pulses once) and offending channel
//   busy_o, halt_o     : state != IDLE, state == HALT
//   halt_clr_i         : leave HALT
//   active_ch_o        : channel owning the pair
//   strm               : streamer-pair control bundle
module dma_stream_sched
  import dma_pkg::*;
#(
  parameter  int NUM_CH         = 4,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int IDX_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_CH-1:0]  ch_req_valid_i,
  input  s_dma_desc_t        ch_desc_i [NUM_CH],
  output logic [NUM_CH-1:0]  ch_req_ready_o,
  output logic [NUM_CH-1:0]  ch_done_o,
  output s_dma_error_t       ch_err_o,
  output logic [IDX_W-1:0]   ch_err_id_o,
  output logic               busy_o,
  output logic               halt_o,
  input  logic               halt_clr_i,
  output logic [IDX_W-1:0]   active_ch_o,
  dma_stream_sched_if.master strm
);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  dma_sched_st_t     state;
  s_dma_desc_t       desc_q;
  logic [IDX_W-1:0]  active_q;
  logic [IDX_W-1:0]  rr_ptr;
  logic [WD_W-1:0]   wd_cnt;
  logic              go_q;
  logic              rd_valid_ff, wr_valid_ff;
  logic              rd_done_seen, wr_done_seen;

  logic [NUM_CH-1:0] grant_oh;
  logic [IDX_W-1:0]  grant_idx;
  s_dma_error_t      rd_err, wr_err;
  logic              rd_fin, wr_fin, wd_expired;

  function automatic logic [IDX_W-1:0] next_ch(input logic [IDX_W-1:0] c);
    return (int'(c) == NUM_CH - 1) ? '0 : c + 1'b1;
  endfunction

  dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i       (ch_req_valid_i),
    .ptr_i       (rr_ptr),
    .grant_o     (grant_oh),
    .grant_idx_o (grant_idx)
  );

  assign rd_err     = strm.rd_stream_err_i;
  assign wr_err     = strm.wr_stream_err_i;
  // A done pulse in the current cycle counts as seen, so same-cycle dones finish at once.
  assign rd_fin     = rd_done_seen | strm.rd_stream_done_i;
  assign wr_fin     = wr_done_seen | strm.wr_stream_done_i;
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LIMIT);

  // Gated by rstn so that every output reads zero while reset is held.
  assign ch_req_ready_o         = (rstn && state == SCHED_IDLE) ? grant_oh : '0;
  assign busy_o                 = (state != SCHED_IDLE);
  assign halt_o                 = (state == SCHED_HALT);
  assign active_ch_o            = active_q;
  assign strm.dma_go_o          = go_q;
  assign strm.dma_desc_o        = desc_q;
  assign strm.rd_stream_valid_o = rd_valid_ff;
  assign strm.wr_stream_valid_o = wr_valid_ff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= SCHED_IDLE;
      desc_q       <= '0;
      active_q     <= '0;
      rr_ptr       <= '0;
      wd_cnt       <= '0;
      go_q         <= 1'b0;
      rd_valid_ff  <= 1'b0;
      wr_valid_ff  <= 1'b0;
      rd_done_seen <= 1'b0;
      wr_done_seen <= 1'b0;
      ch_done_o    <= '0;
      ch_err_o     <= '0;
      ch_err_id_o  <= '0;
    end else begin
      go_q           <= 1'b0;
      ch_done_o      <= '0;
      ch_err_o.valid <= 1'b0;
      case (state)
        SCHED_IDLE: begin
          if (|ch_req_valid_i) begin
            desc_q   <= ch_desc_i[grant_idx];
            active_q <= grant_idx;
            go_q     <= 1'b1;
            state    <= SCHED_GO;
          end
        end
        SCHED_GO: begin
          rd_valid_ff  <= 1'b1;
          wr_valid_ff  <= 1'b1;
          rd_done_seen <= 1'b0;
          wr_done_seen <= 1'b0;
          wd_cnt       <= '0;
          state        <= SCHED_RUN;
        end
        SCHED_RUN: begin
          if (rd_err.valid || wr_err.valid) begin
            ch_err_o    <= rd_err.valid ? rd_err : wr_err;
            ch_err_id_o <= active_q;
            rd_valid_ff <= 1'b0;
            wr_valid_ff <= 1'b0;
            state       <= SCHED_HALT;
          end else if (wd_expired) begin
            ch_err_o    <= '{valid: 1'b1, src: DMA_TIMEOUT_ERR, addr: desc_q.src_addr};
            ch_err_id_o <= active_q;
            rd_valid_ff <= 1'b0;
            wr_valid_ff <= 1'b0;
            state       <= SCHED_HALT;
          end else if (rd_fin && wr_fin) begin
            ch_done_o[active_q] <= 1'b1;
            rd_valid_ff         <= 1'b0;
            wr_valid_ff         <= 1'b0;
            state               <= SCHED_RESP;
          end else begin
            // Drop each valid right after its own done so an idle streamer does not restart.
            if (strm.rd_stream_done_i) begin
              rd_valid_ff  <= 1'b0;
              rd_done_seen <= 1'b1;
            end
            if (strm.wr_stream_done_i) begin
              wr_valid_ff  <= 1'b0;
              wr_done_seen <= 1'b1;
            end
            if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
          end
        end
        SCHED_RESP: begin
          rr_ptr <= next_ch(active_q);
          state  <= SCHED_IDLE;
        end
        SCHED_HALT: begin
          if (halt_clr_i) begin
            rr_ptr <= next_ch(active_q);
            state  <= SCHED_IDLE;
          end
        end
        default: state <= SCHED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_stream_sched.sv
// tb_dma_stream_sched
// Directed scenarios plus a randomized run against a transaction-level model of
// the scheduler (round-robin pointer, grant, completion or error per descriptor).
module tb_dma_stream_sched;
  import dma_pkg::*;

  logic         clk;
  logic         rstn;
  logic [3:0]   req;
  s_dma_desc_t  desc [4];
  logic [3:0]   ready;
  logic [3:0]   done;
  s_dma_error_t err;
  logic [1:0]   err_id;
  logic         busy;
  logic         halt;
  logic         halt_clr;
  logic [1:0]   active;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;

  dma_stream_sched_if sif ();

  dma_stream_sched #(.NUM_CH(4), .TIMEOUT_CYCLES(20)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .ch_req_valid_i (req),
    .ch_desc_i      (desc),
    .ch_req_ready_o (ready),
    .ch_done_o      (done),
    .ch_err_o       (err),
    .ch_err_id_o    (err_id),
    .busy_o         (busy),
    .halt_o         (halt),
    .halt_clr_i     (halt_clr),
    .active_ch_o    (active),
    .strm           (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference round-robin: first requester scanning upward from the pointer.
  function automatic int model_grant(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    req = '0;
    halt_clr = 1'b0;
    sif.rd_stream_done_i = 1'b0;
    sif.wr_stream_done_i = 1'b0;
    sif.rd_stream_err_i = '0;
    sif.wr_stream_err_i = '0;
    for (int c = 0; c < 4; c++) desc[c] = '0;
    repeat (2) step();
    rstn = 1'b1;
    exp_ptr = 0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({busy, halt, sif.dma_go_o} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {busy, halt, sif.dma_go_o}); end
    checks++; if ({sif.rd_stream_valid_o, sif.wr_stream_valid_o} !== 2'b00) begin errors++; $display("FAIL reset_valids got %b exp 00", {sif.rd_stream_valid_o, sif.wr_stream_valid_o}); end
    checks++; if ({ready, done, active, err_id} !== 12'h000) begin errors++; $display("FAIL reset_chan got %h exp 000", {ready, done, active, err_id}); end
    checks++; if (err !== '0 || sif.dma_desc_o !== '0) begin errors++; $display("FAIL reset_err_desc got %h/%h exp 0", err, sif.dma_desc_o); end
  endtask

  task automatic test_single();
    s_dma_desc_t d;
    d = '{src_addr: 32'h1000, dst_addr: 32'h2000, num_bytes: 16'd128};
    desc[1] = d;
    req = 4'b0010;
    #1;
    checks++; if (ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b exp 0010", ready); end
    step(); req = '0;                                           // T+1
    checks++; if (sif.dma_go_o !== 1'b1 || sif.dma_desc_o !== d) begin errors++; $display("FAIL single_go got %b/%h exp 1/%h", sif.dma_go_o, sif.dma_desc_o, d); end
    step();                                                     // T+2
    checks++; if ({sif.dma_go_o, sif.rd_stream_valid_o, sif.wr_stream_valid_o} !== 3'b011) begin errors++; $display("FAIL single_valids got %b exp 011", {sif.dma_go_o, sif.rd_stream_valid_o, sif.wr_stream_valid_o}); end
    repeat (4) step(); sif.rd_stream_done_i = 1'b1;             // T+6
    step(); sif.rd_stream_done_i = 1'b0;                        // T+7
    checks++; if ({sif.rd_stream_valid_o, sif.wr_stream_valid_o} !== 2'b01) begin errors++; $display("FAIL single_rd_drop got %b exp 01", {sif.rd_stream_valid_o, sif.wr_stream_valid_o}); end
    step(); step(); sif.wr_stream_done_i = 1'b1;                // T+9
    step(); sif.wr_stream_done_i = 1'b0;                        // T+10
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL single_done got %b exp 0010", done); end
    step();                                                     // T+11
    checks++; if ({busy, done} !== 5'b00000) begin errors++; $display("FAIL single_idle got %b exp 00000", {busy, done}); end
    exp_ptr = 2;
  endtask

  task automatic test_rr();
    int g;
    do_reset();
    req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      #1;
      g = model_grant(req, exp_ptr);
      checks++; if (ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", n, ready, 4'(1 << g)); end
      step();
      checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL rr_ready_go%0d got %b exp 0000", n, ready); end
      step(); sif.rd_stream_done_i = 1'b1; sif.wr_stream_done_i = 1'b1;
      step(); sif.rd_stream_done_i = 1'b0; sif.wr_stream_done_i = 1'b0;
      checks++; if (done !== 4'(1 << g)) begin errors++; $display("FAIL rr_done%0d got %b exp %b", n, done, 4'(1 << g)); end
      exp_ptr = (g + 1) % 4;
      step();
    end
    req = '0;
  endtask

  task automatic test_error();
    s_dma_error_t e;
    e = '{valid: 1'b1, src: DMA_UNALIGNED_ERR, addr: 32'h2004};
    desc[0] = '{src_addr: 32'h3000, dst_addr: 32'h2000, num_bytes: 16'd64};
    req = 4'b0001;
    #1;
    checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL err_ready got %b exp 0001", ready); end
    step(); req = '0;
    step(); step(); step();                                     // RUN+2
    sif.wr_stream_err_i = e; req = 4'b0010;
    step();                                                     // E+1
    checks++; if (err !== e || err_id !== 2'd0) begin errors++; $display("FAIL err_record got %h/%0d exp %h/0", err, err_id, e); end
    checks++; if ({halt, sif.rd_stream_valid_o, sif.wr_stream_valid_o, ready} !== 7'b1000000) begin errors++; $display("FAIL err_halt got %b exp 1000000", {halt, sif.rd_stream_valid_o, sif.wr_stream_valid_o, ready}); end
    step();
    checks++; if ({err.valid, halt, ready} !== 6'b010000) begin errors++; $display("FAIL err_hold got %b exp 010000", {err.valid, halt, ready}); end
    sif.wr_stream_err_i = '0;
    step(); halt_clr = 1'b1; req = 4'b0011;
    step(); halt_clr = 1'b0;
    #1;
    checks++; if (ready !== 4'b0010) begin errors++; $display("FAIL err_resume got %b exp 0010", ready); end
    step(); req = '0;
    step(); sif.rd_stream_done_i = 1'b1; sif.wr_stream_done_i = 1'b1;
    step(); sif.rd_stream_done_i = 1'b0; sif.wr_stream_done_i = 1'b0;
    step();
    exp_ptr = 2;
  endtask

  task automatic test_timeout();
    s_dma_error_t e;
    e = '{valid: 1'b1, src: DMA_TIMEOUT_ERR, addr: 32'hABCD0000};
    desc[3] = '{src_addr: 32'hABCD0000, dst_addr: 32'h5000, num_bytes: 16'd256};
    req = 4'b1000;
    #1;
    checks++; if (ready !== 4'b1000) begin errors++; $display("FAIL to_ready got %b exp 1000", ready); end
    step(); req = '0;
    step();                                                     // RUN entry R
    repeat (20) step();                                         // R+20
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", halt); end
    step();                                                     // R+21
    checks++; if (halt !== 1'b1 || err !== e || err_id !== 2'd3) begin errors++; $display("FAIL to_halt got %b/%h/%0d exp 1/%h/3", halt, err, err_id, e); end
    step(); halt_clr = 1'b1;
    step(); halt_clr = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", busy); end
    exp_ptr = 0;
  endtask

  task automatic test_simul_done();
    req = 4'b0001;
    #1;
    checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL sd_ready got %b exp 0001", ready); end
    step(); req = '0; sif.rd_stream_done_i = 1'b1; sif.wr_stream_done_i = 1'b1;   // dones in GO are ignored
    step(); sif.rd_stream_done_i = 1'b0; sif.wr_stream_done_i = 1'b0;
    checks++; if ({sif.rd_stream_valid_o, sif.wr_stream_valid_o} !== 2'b11) begin errors++; $display("FAIL sd_go_ignored got %b exp 11", {sif.rd_stream_valid_o, sif.wr_stream_valid_o}); end
    step();
    checks++; if ({busy, done} !== 5'b10000) begin errors++; $display("FAIL sd_no_early got %b exp 10000", {busy, done}); end
    step(); step(); sif.rd_stream_done_i = 1'b1; sif.wr_stream_done_i = 1'b1;
    step(); sif.rd_stream_done_i = 1'b0; sif.wr_stream_done_i = 1'b0;
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL sd_done got %b exp 0001", done); end
    step();
    exp_ptr = 1;
  endtask

  task automatic test_async_reset();
    desc[3] = '{src_addr: 32'h7000, dst_addr: 32'h8000, num_bytes: 16'd32};
    req = 4'b1000;
    #1;
    checks++; if (ready !== 4'b1000) begin errors++; $display("FAIL ar_ready got %b exp 1000", ready); end
    step(); req = '0;
    step(); step();
    #2 rstn = 1'b0;
    #1;
    checks++; if ({busy, halt, sif.dma_go_o, sif.rd_stream_valid_o, sif.wr_stream_valid_o, active, done, ready} !== 15'h0) begin errors++; $display("FAIL ar_outputs got %h exp 0", {busy, halt, sif.dma_go_o, sif.rd_stream_valid_o, sif.wr_stream_valid_o, active, done, ready}); end
    checks++; if (sif.dma_desc_o !== '0 || err !== '0) begin errors++; $display("FAIL ar_desc_err got %h/%h exp 0", sif.dma_desc_o, err); end
    step(); rstn = 1'b1; exp_ptr = 0;
    step(); req = 4'b1100;
    #1;
    checks++; if (ready !== 4'b0100) begin errors++; $display("FAIL ar_ptr got %b exp 0100", ready); end
    step(); req = '0;
    step(); sif.rd_stream_done_i = 1'b1; sif.wr_stream_done_i = 1'b1;
    step(); sif.rd_stream_done_i = 1'b0; sif.wr_stream_done_i = 1'b0;
    checks++; if (done !== 4'b0100) begin errors++; $display("FAIL ar_done got %b exp 0100", done); end
    step();
    exp_ptr = 3;
  endtask

  task automatic test_random();
    int g, rd_d, wr_d, last, e, side;
    s_dma_error_t rerr, werr, xerr;
    for (int n = 0; n < 40; n++) begin
      for (int c = 0; c < 4; c++) desc[c] = '{src_addr: $urandom, dst_addr: $urandom, num_bytes: 16'($urandom)};
      req = 4'($urandom_range(1, 15));
      g = model_grant(req, exp_ptr);
      #1;
      checks++; if (ready !== 4'(1 << g)) begin errors++; $display("FAIL rnd%0d_ready got %b exp %b", n, ready, 4'(1 << g)); end
      step(); req = '0;
      checks++; if (sif.dma_go_o !== 1'b1 || sif.dma_desc_o !== desc[g] || active !== 2'(g)) begin errors++; $display("FAIL rnd%0d_go got %b/%h/%0d exp 1/%h/%0d", n, sif.dma_go_o, sif.dma_desc_o, active, desc[g], g); end
      step();                                                   // RUN entry
      if ($urandom_range(0, 3) != 0) begin
        rd_d = $urandom_range(0, 6);
        wr_d = $urandom_range(0, 6);
        last = (rd_d > wr_d) ? rd_d : wr_d;
        for (int c = 0; c <= last; c++) begin
          sif.rd_stream_done_i = (c == rd_d);
          sif.wr_stream_done_i = (c == wr_d);
          halt_clr = 1'($urandom_range(0, 1));                  // ignored outside HALT
          #1;
          checks++; if ({sif.rd_stream_valid_o, sif.wr_stream_valid_o} !== {(c <= rd_d), (c <= wr_d)}) begin errors++; $display("FAIL rnd%0d_valid c%0d got %b exp %b", n, c, {sif.rd_stream_valid_o, sif.wr_stream_valid_o}, {(c <= rd_d), (c <= wr_d)}); end
          step();
        end
        sif.rd_stream_done_i = 1'b0; sif.wr_stream_done_i = 1'b0; halt_clr = 1'b0;
        checks++; if (done !== 4'(1 << g) || halt !== 1'b0) begin errors++; $display("FAIL rnd%0d_done got %b/%b exp %b/0", n, done, halt, 4'(1 << g)); end
      end else begin
        e = $urandom_range(0, 5);
        side = $urandom_range(1, 3);
        rerr = '{valid: 1'b1, src: ($urandom_range(0, 1) != 0) ? DMA_UNALIGNED_ERR : DMA_BUS_ERR, addr: $urandom};
        werr = '{valid: 1'b1, src: ($urandom_range(0, 1) != 0) ? DMA_UNALIGNED_ERR : DMA_BUS_ERR, addr: $urandom};
        if (side[0] == 1'b0) rerr = '0;
        if (side[1] == 1'b0) werr = '0;
        xerr = side[0] ? rerr : werr;                           // read side wins a tie
        repeat (e) step();
        sif.rd_stream_err_i = rerr; sif.wr_stream_err_i = werr;
        step();
        checks++; if (err !== xerr || err_id !== 2'(g) || halt !== 1'b1 || {sif.rd_stream_valid_o, sif.wr_stream_valid_o, done} !== 6'b0) begin errors++; $display("FAIL rnd%0d_err got %h/%0d/%b exp %h/%0d/1", n, err, err_id, halt, xerr, g); end
        sif.rd_stream_err_i = '0; sif.wr_stream_err_i = '0;
        step(); halt_clr = 1'b1;
        step(); halt_clr = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_clear got %b exp 0", n, busy); end
      end
      exp_ptr = (g + 1) % 4;
      if (busy) step();                                         // RESP -> IDLE
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_error();
    test_timeout();
    test_simul_done();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
